multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a multi-cycle RV32I datapath: one shared memory for instructions and data, one ALU reused for PC increment, address generation and branch targets.
- Sits beside the datapath. Takes opcode/funct fields from the instruction register (IR), which holds its value after FETCH, and takes alu_eq from the ALU.
- Drives register enables, mux selects and memory strobes.
- Waits on a memory ready handshake, so memory latency is variable.

Parameters:
- RESET_PC, 32'h0000_0000, PC value requested via pc_init on reset exit.
- MEM_TIMEOUT, 16, maximum mem_ready wait in cycles before entering TRAP; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- alu_eq  in  1  ALU a==b
- mem_ready  in  1  memory completed the current mem_read/mem_write this cycle
- pc_init  out  1  load RESET_PC into PC
- pc_write  out  1  PC <= pc_src result
- ir_write  out  1  IR and old_pc <= memory data / PC
- reg_write  out  1  register file write
- mem_read  out  1  memory read strobe, held until mem_ready
- mem_write  out  1  memory write strobe, held until mem_ready
- adr_sel  out  1  0 = PC, 1 = ALU-out register
- alu_src_a  out  2  0 = PC, 1 = old_pc, 2 = rs1
- alu_src_b  out  2  0 = rs2, 1 = imm_ext, 2 = constant 4
- alu_op  out  4  alu_op_t
- sign_extend_type  out  3  sign_extend_t
- result_sel  out  2  0 = ALU result, 1 = ALU-out register, 2 = memory data
- state_out  out  4  current state, for checking
- trap  out  1  sticky illegal-opcode or timeout flag

Behaviour:
- States: RESET_S, FETCH, DECODE, EXEC_R, EXEC_I, LUI_EX, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, JAL_S, JALR_S, BRANCH_S, TRAP.
- Reset (sync):
  - State becomes RESET_S and trap clears.
  - All strobes and enables are 0; selects are 0; alu_op = ADD.
- RESET_S: pc_init = 1 for one cycle, then FETCH.
- FETCH:
  - Drives mem_read = 1, adr_sel = 0, alu_src_a = 0, alu_src_b = 2, alu_op = ADD, result_sel = 0.
  - When mem_ready = 1: assert ir_write and pc_write (PC <= PC+4) in that same cycle, then go to DECODE.
  - Otherwise hold FETCH with outputs unchanged.
- DECODE:
  - Computes the branch target old_pc + imm (alu_src_a = 1, alu_src_b = 1, sign_extend_type = BRANCH_SE) into the ALU-out register.
  - Dispatches on opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0110111 → LUI_EX
    - 0000011 or 0100011 → MEM_ADR
    - 1101111 → JAL_S
    - 1100111 → JALR_S
    - 1100011 → BRANCH_S
    - any other opcode → TRAP
- EXEC_R:
  - alu_op decoded from funct3/funct7: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - Unlisted funct7 with funct3 = 000 → TRAP.
  - Next state ALU_WB.
- EXEC_I:
  - funct3 000/100/110/111 → ADD/XOR/OR/AND with ADDI_SE.
  - funct3 001 → SLL with SLLI_SE.
  - funct3 101 → SRL or SRA (funct7 0000000 / 0100000) with SLLI_SE.
  - funct3 010/011 → TRAP.
  - Next state ALU_WB.
- LUI_EX: alu_op = BPASS, alu_src_b = 1, LUI_SE; next ALU_WB.
- ALU_WB: reg_write = 1, result_sel = 1; next FETCH.
- MEM_ADR:
  - rs1 + imm, using ADDI_SE for load and SW_SE for store.
  - Next MEM_RD for opcode 0000011, MEM_WR for 0100011.
- MEM_RD: mem_read = 1, adr_sel = 1; on mem_ready go to MEM_WB.
- MEM_WR: mem_write = 1, adr_sel = 1; on mem_ready go to FETCH.
- MEM_WB: reg_write = 1, result_sel = 2; next FETCH.
- JAL_S:
  - reg_write with rd <= PC (already PC+4): alu_src_a = 0, alu_src_b = 2 is not used; result_sel = 0 with alu_op = BPASS of PC.
  - pc_write of old_pc + J-imm (JAL_SE).
  - The team allows a second cycle here, ALU_WB-like, if the ALU is needed twice; implementation choice, but latency must be 4 cycles total (FETCH with ready = 1 through JAL_S).
- JALR_S: same pattern as JAL_S; target is (rs1 + I-imm) & ~1.
- BRANCH_S:
  - alu_op = SUB comparing rs1, rs2.
  - pc_write = (funct3 == 000 & alu_eq) | (funct3 == 001 & ~alu_eq), with result_sel = 1 (the DECODE target).
  - Any other funct3 → TRAP.
  - Next FETCH.
- TRAP: absorbing state; all strobes 0; trap = 1 until reset.
- Timeout: a counter of consecutive cycles in FETCH/MEM_RD/MEM_WR with mem_ready = 0; reaching MEM_TIMEOUT → TRAP. Counter clears on every state change.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset mid-access drops mem_read/mem_write in the next cycle.
- No outputs are X in any state; defaults are assigned before the case.
- Latencies with mem_ready immediate:
  - R-type, I-type, LUI, JAL/JALR: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - branch: 3 cycles

Decomposition:
- Shared package rv32i_pkg holds:
  - alu_op_t (ADD = 0 … BPASS = 9)
  - opcode_t
  - sign_extend_t extended with BRANCH_SE = 4, JAL_SE = 5
  - new enums ctrl_state_t, alu_src_a_t, alu_src_b_t, result_sel_t
- One sub-module: alu_decoder (combinational, funct3/funct7/class → alu_op plus illegal flag).

Test Plan:
- add x3,x1,x2 with mem_ready = 1 → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write = 1 exactly in cycle 4; alu_op = ADD (0); pc_write once.
- lw with mem_ready low for 3 cycles in MEM_RD → mem_read held for 4 cycles; reg_write in MEM_WB only; total 8 cycles.
- beq with alu_eq = 1, then bne with alu_eq = 1 → pc_write = 1 in BRANCH_S for beq, pc_write = 0 for bne.
- opcode 7'b1111111 → TRAP after DECODE; trap = 1 sticky; no strobes; reset returns state_out to RESET_S, then FETCH.
- MEM_TIMEOUT = 16 with mem_ready stuck at 0 in FETCH → TRAP entered on the 16th wait cycle.
- Reset asserted during MEM_WR → mem_write = 0 the following cycle; pc_init = 1 after reset is released.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I encodings and multi-cycle controller enums
// Purpose: ALU operations, opcodes, immediate formats, controller states and
//          datapath mux select encodings used by the controller and its decoder.
// Ports:   none (package).
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_BPASS = 4'd9
    } alu_op_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        ADDI_SE   = 3'd0,
        SW_SE     = 3'd1,
        SLLI_SE   = 3'd2,
        LUI_SE    = 3'd3,
        BRANCH_SE = 3'd4,
        JAL_SE    = 3'd5
    } sign_extend_t;

    typedef enum logic [3:0] {
        RESET_S  = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        LUI_EX   = 4'd5,
        MEM_ADR  = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        ALU_WB   = 4'd10,
        JAL_S    = 4'd11,
        JALR_S   = 4'd12,
        BRANCH_S = 4'd13,
        TRAP     = 4'd14,
        LINK_WB  = 4'd15
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_RS1    = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALU     = 2'd0,
        RES_ALU_OUT = 2'd1,
        RES_MEM     = 2'd2
    } result_sel_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - funct3/funct7 to ALU operation decoder
// Purpose: combinational decode of OP (register) and OP-IMM instructions.
// Ports:   i_funct3, i_funct7 - IR fields
//          i_is_imm           - 1 for OP-IMM, 0 for OP
//          o_alu_op           - selected ALU operation
//          o_illegal          - encoding not supported, controller traps
module alu_decoder
    import rv32i_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_is_imm,
    output alu_op_t    o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        if (!i_is_imm) begin
            case (i_funct3)
                3'b000: begin
                    if (i_funct7 == 7'b0100000)      o_alu_op  = ALU_SUB;
                    else if (i_funct7 != 7'b0000000) o_illegal = 1'b1;
                end
                3'b001:  o_alu_op = ALU_SLL;
                // SLTU shares the signed comparator in this datapath
                3'b010,
                3'b011:  o_alu_op = ALU_SLT;
                3'b100:  o_alu_op = ALU_XOR;
                3'b101:  o_alu_op = ALU_SRL;
                3'b110:  o_alu_op = ALU_OR;
                default: o_alu_op = ALU_AND;
            endcase
        end else begin
            case (i_funct3)
                3'b000:  o_alu_op = ALU_ADD;
                3'b001:  o_alu_op = ALU_SLL;
                3'b100:  o_alu_op = ALU_XOR;
                3'b101: begin
                    if (i_funct7 == 7'b0000000)      o_alu_op  = ALU_SRL;
                    else if (i_funct7 == 7'b0100000) o_alu_op  = ALU_SRA;
                    else                             o_illegal = 1'b1;
                end
                3'b110:  o_alu_op = ALU_OR;
                3'b111:  o_alu_op = ALU_AND;
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I datapath sequencer
// Purpose: steps a shared-memory, single-ALU RV32I datapath through fetch,
//          decode, execute, memory and writeback, with a memory wait timeout.
// Ports:   clk, reset (sync, active-high)
//          i_opcode/i_funct3/i_funct7 - IR fields, i_alu_eq - ALU a==b
//          i_mem_ready                - memory handshake for the current strobe
//          o_pc_init/o_pc_write/o_ir_write/o_reg_write - register enables
//          o_mem_read/o_mem_write     - memory strobes, held until i_mem_ready
//          o_adr_sel/o_alu_src_a/o_alu_src_b/o_alu_op/o_sign_extend_type/
//          o_result_sel               - datapath selects
//          o_state_out                - current state, o_trap - sticky fault
module multicycle_controller
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_alu_eq,
    input  logic       i_mem_ready,
    output logic       o_pc_init,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_adr_sel,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_alu_op,
    output logic [2:0] o_sign_extend_type,
    output logic [1:0] o_result_sel,
    output logic [3:0] o_state_out,
    output logic       o_trap
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    ctrl_state_t  r_state;
    logic         r_trap;
    logic [CNT_W-1:0] r_wait_cnt;

    ctrl_state_t  w_next_state;
    logic         w_pc_init, w_pc_write, w_ir_write, w_reg_write;
    logic         w_mem_read, w_mem_write, w_adr_sel;
    alu_src_a_t   w_src_a;
    alu_src_b_t   w_src_b;
    alu_op_t      w_alu_op;
    sign_extend_t w_sext;
    result_sel_t  w_result_sel;

    alu_op_t      w_dec_op;
    logic         w_dec_illegal;
    logic         w_dec_is_imm;
    logic         w_mem_state;
    logic         w_waiting;
    logic         w_timeout;
    logic         w_unused;

    // The PC mux in the datapath holds RESET_PC; the controller only requests it.
    assign w_unused = ^RESET_PC;

    assign w_dec_is_imm = (r_state == EXEC_I);

    alu_decoder u_alu_decoder (
        .i_funct3  (i_funct3),
        .i_funct7  (i_funct7),
        .i_is_imm  (w_dec_is_imm),
        .o_alu_op  (w_dec_op),
        .o_illegal (w_dec_illegal)
    );

    assign w_mem_state = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    assign w_waiting   = w_mem_state && !i_mem_ready;
    // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_waiting
                         && (32'(r_wait_cnt) == MEM_TIMEOUT - 1);

    always_comb begin
        w_next_state = r_state;
        w_pc_init    = 1'b0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_sel    = 1'b0;
        w_src_a      = SRC_A_PC;
        w_src_b      = SRC_B_RS2;
        w_alu_op     = ALU_ADD;
        w_sext       = ADDI_SE;
        w_result_sel = RES_ALU;

        case (r_state)
            RESET_S: begin
                w_pc_init    = 1'b1;
                w_next_state = FETCH;
            end
            FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = SRC_B_FOUR;
                if (i_mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = DECODE;
                end else if (w_timeout) begin
                    w_next_state = TRAP;
                end
            end
            DECODE: begin
                // Branch target is precomputed here into the ALU-out register.
                w_src_a = SRC_A_OLD_PC;
                w_src_b = SRC_B_IMM;
                w_sext  = BRANCH_SE;
                case (i_opcode)
                    OP_REG:            w_next_state = EXEC_R;
                    OP_IMM:            w_next_state = EXEC_I;
                    OP_LUI:            w_next_state = LUI_EX;
                    OP_LOAD, OP_STORE: w_next_state = MEM_ADR;
                    OP_JAL:            w_next_state = JAL_S;
                    OP_JALR:           w_next_state = JALR_S;
                    OP_BRANCH:         w_next_state = BRANCH_S;
                    default:           w_next_state = TRAP;
                endcase
            end
            EXEC_R: begin
                w_src_a      = SRC_A_RS1;
                w_alu_op     = w_dec_op;
                w_next_state = w_dec_illegal ? TRAP : ALU_WB;
            end
            EXEC_I: begin
                w_src_a      = SRC_A_RS1;
                w_src_b      = SRC_B_IMM;
                w_alu_op     = w_dec_op;
                w_sext       = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? SLLI_SE : ADDI_SE;
                w_next_state = w_dec_illegal ? TRAP : ALU_WB;
            end
            LUI_EX: begin
                w_src_b      = SRC_B_IMM;
                w_alu_op     = ALU_BPASS;
                w_sext       = LUI_SE;
                w_next_state = ALU_WB;
            end
            ALU_WB: begin
                w_reg_write  = 1'b1;
                w_result_sel = RES_ALU_OUT;
                w_next_state = FETCH;
            end
            MEM_ADR: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
                w_sext  = (i_opcode == OP_STORE) ? SW_SE : ADDI_SE;
                if (i_opcode == OP_STORE)     w_next_state = MEM_WR;
                else if (i_opcode == OP_LOAD) w_next_state = MEM_RD;
                else                          w_next_state = TRAP;
            end
            MEM_RD: begin
                w_mem_read = 1'b1;
                w_adr_sel  = 1'b1;
                if (i_mem_ready)    w_next_state = MEM_WB;
                else if (w_timeout) w_next_state = TRAP;
            end
            MEM_WR: begin
                w_mem_write = 1'b1;
                w_adr_sel   = 1'b1;
                if (i_mem_ready)    w_next_state = FETCH;
                else if (w_timeout) w_next_state = TRAP;
            end
            MEM_WB: begin
                w_reg_write  = 1'b1;
                w_result_sel = RES_MEM;
                w_next_state = FETCH;
            end
            // Jumps redirect PC first, then LINK_WB writes rd <= old_pc + 4.
            // old_pc is untouched until the next fetch, so rs1 == rd is safe.
            JAL_S: begin
                w_src_a      = SRC_A_OLD_PC;
                w_src_b      = SRC_B_IMM;
                w_sext       = JAL_SE;
                w_pc_write   = 1'b1;
                w_next_state = LINK_WB;
            end
            JALR_S: begin
                // Bit 0 of the target is cleared at the datapath PC input.
                w_src_a      = SRC_A_RS1;
                w_src_b      = SRC_B_IMM;
                w_pc_write   = 1'b1;
                w_next_state = LINK_WB;
            end
            LINK_WB: begin
                w_src_a      = SRC_A_OLD_PC;
                w_src_b      = SRC_B_FOUR;
                w_reg_write  = 1'b1;
                w_next_state = FETCH;
            end
            BRANCH_S: begin
                w_src_a      = SRC_A_RS1;
                w_alu_op     = ALU_SUB;
                w_result_sel = RES_ALU_OUT;
                w_next_state = FETCH;
                case (i_funct3)
                    3'b000:  w_pc_write   = i_alu_eq;
                    3'b001:  w_pc_write   = !i_alu_eq;
                    default: w_next_state = TRAP;
                endcase
            end
            TRAP: begin
                w_next_state = TRAP;
            end
            default: begin
                w_next_state = TRAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RESET_S;
            r_trap     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == TRAP) r_trap <= 1'b1;
            if (w_next_state != r_state) r_wait_cnt <= '0;
            else if (w_waiting)          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // pc_init is masked while reset is held so every strobe is low in reset.
    assign o_pc_init          = w_pc_init && !reset;
    assign o_pc_write         = w_pc_write;
    assign o_ir_write         = w_ir_write;
    assign o_reg_write        = w_reg_write;
    assign o_mem_read         = w_mem_read;
    assign o_mem_write        = w_mem_write;
    assign o_adr_sel          = w_adr_sel;
    assign o_alu_src_a        = w_src_a;
    assign o_alu_src_b        = w_src_b;
    assign o_alu_op           = w_alu_op;
    assign o_sign_extend_type = w_sext;
    assign o_result_sel       = w_result_sel;
    assign o_state_out        = r_state;
    assign o_trap             = r_trap;

endmodule
